mem_wb_stage: RTL and testbench

- MEM/WB pipeline stage: consumes EX/MEM results and performs word/half-word/byte loads and stores over a req/ack data-memory bus.
- Drives the register-file write-back interface (WB_reg_write_address, WB_reg_write_data, WB_ctrl_reg_write) consumed by the decode stage.
- Stalls the pipeline while a memory access is outstanding.

---
 rtl/mem_wb_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage.
//   Takes EX/MEM results, performs big-endian word/half/byte loads and stores
//   over a single-outstanding req/ack data-memory bus, and drives the
//   register-file write-back port. The pipeline is stalled while an access
//   is in flight.
//
// Ports:
//   clk_i, n_rst_i            clock, asynchronous active-low reset
//   EXMEM_*_i                 instruction from EX/MEM (held stable while stall_o=1)
//   dmem_req_o/we_o/addr_o/be_o/wdata_o, dmem_rdata_i/ack_i   data-memory bus
//   stall_o                   hold EX/MEM and earlier stages
//   WB_reg_write_address_o/WB_reg_write_data_o/WB_ctrl_reg_write_o
//                             registered register-file write port
//   misalign_o                sticky: a misaligned access was suppressed
//   bus_err_o                 sticky: a bus access timed out
//
// Optional feature: define DMEM_TIMEOUT_EN to abort an access after
// DMEM_TIMEOUT busy cycles without ack. Without it the stage waits forever
// and bus_err_o is tied low.

module mem_wb_stage #(
  parameter int unsigned DMEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        EXMEM_valid_i,
  input  logic [31:0] EXMEM_alu_result_i,
  input  logic [31:0] EXMEM_b_i,
  input  logic [4:0]  EXMEM_dst_i,
  input  logic [1:0]  EXMEM_ctrl_mem_read_i,
  input  logic [1:0]  EXMEM_ctrl_mem_write_i,
  input  logic        EXMEM_ctrl_reg_write_i,
  input  logic        EXMEM_ctrl_mem_to_reg_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic [4:0]  WB_reg_write_address_o,
  output logic [31:0] WB_reg_write_data_o,
  output logic        WB_ctrl_reg_write_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;
  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_WORD = 2'd1,
    SZ_HALF = 2'd2,
    SZ_BYTE = 2'd3
  } size_e;

  if (DMEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("DMEM_TIMEOUT must be at least 1");
  end

  state_e      state_q, state_d;

  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic        wb_we_q;
  logic        misalign_q;

  logic        is_store, mem_op, misaligned;
  size_e       size;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data;
  logic        start, done, retire, suppress, timeout;

  // ---------------------------------------------------------------------------
  // Access decode: a nonzero mem_write overrides mem_read.
  // ---------------------------------------------------------------------------
  always_comb begin
    is_store   = (EXMEM_ctrl_mem_write_i != 2'd0);
    size       = is_store ? size_e'(EXMEM_ctrl_mem_write_i)
                          : size_e'(EXMEM_ctrl_mem_read_i);
    mem_op     = EXMEM_valid_i && (size != SZ_NONE);
    misaligned = mem_op && (((size == SZ_WORD) && (EXMEM_alu_result_i[1:0] != 2'b00)) ||
                            ((size == SZ_HALF) && EXMEM_alu_result_i[0]));
  end

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    be_d    = '0;
    wdata_d = '0;
    unique case (size)
      SZ_WORD: begin
        be_d    = 4'b1111;
        wdata_d = EXMEM_b_i;
      end
      SZ_HALF: begin
        be_d    = EXMEM_alu_result_i[1] ? 4'b0011 : 4'b1100;
        wdata_d = {2{EXMEM_b_i[15:0]}};
      end
      SZ_BYTE: begin
        be_d    = 4'b1000 >> EXMEM_alu_result_i[1:0];
        wdata_d = {4{EXMEM_b_i[7:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the live EX/MEM fields: they are held for the whole
  // access, including the ack cycle.
  always_comb begin
    load_data = dmem_rdata_i;
    unique case (size)
      SZ_HALF: begin
        if (EXMEM_alu_result_i[1])
          load_data = {{16{dmem_rdata_i[15]}}, dmem_rdata_i[15:0]};
        else
          load_data = {{16{dmem_rdata_i[31]}}, dmem_rdata_i[31:16]};
      end
      SZ_BYTE: begin
        unique case (EXMEM_alu_result_i[1:0])
          2'd0: load_data = {{24{dmem_rdata_i[31]}}, dmem_rdata_i[31:24]};
          2'd1: load_data = {{24{dmem_rdata_i[23]}}, dmem_rdata_i[23:16]};
          2'd2: load_data = {{24{dmem_rdata_i[15]}}, dmem_rdata_i[15:8]};
          default: load_data = {{24{dmem_rdata_i[7]}}, dmem_rdata_i[7:0]};
        endcase
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional bus timeout. The counter holds the number of ack-less BUSY cycles
  // already completed; the cycle that would make it reach DMEM_TIMEOUT aborts.
  // ---------------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(DMEM_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt_q;
  logic          bus_err_q;

  assign timeout = (state_q == S_BUSY) && !dmem_ack_i && (wait_cnt_q == TO_LAST);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      if ((state_q == S_BUSY) && !dmem_ack_i && !timeout)
        wait_cnt_q <= wait_cnt_q + CW'(1);
      else
        wait_cnt_q <= '0;
      if (timeout)
        bus_err_q <= 1'b1;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state, stall and retirement.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    done     = 1'b0;
    retire   = 1'b0;
    suppress = 1'b0;
    stall_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start    = mem_op && !misaligned;
        retire   = EXMEM_valid_i && !start;
        suppress = misaligned;
        stall_o  = start;
        if (start)
          state_d = S_BUSY;
      end
      S_BUSY: begin
        // ack wins over a coincident timeout
        done     = dmem_ack_i || timeout;
        retire   = done;
        suppress = !dmem_ack_i;
        stall_o  = !done;
        if (done)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The pipeline is being reset anyway; keep every output low meanwhile.
    if (!n_rst_i)
      stall_o = 1'b0;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_we_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= is_store;
        addr_q  <= {EXMEM_alu_result_i[31:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end else if (done) begin
        req_q <= 1'b0;
      end
      wb_we_q <= retire && !suppress && EXMEM_ctrl_reg_write_i && (EXMEM_dst_i != '0);
      if (retire) begin
        wb_addr_q <= EXMEM_dst_i;
        wb_data_q <= EXMEM_ctrl_mem_to_reg_i ? load_data : EXMEM_alu_result_i;
      end
      if ((state_q == S_IDLE) && misaligned)
        misalign_q <= 1'b1;
    end
  end

  assign dmem_req_o             = req_q;
  assign dmem_we_o              = we_q;
  assign dmem_addr_o            = addr_q;
  assign dmem_be_o              = be_q;
  assign dmem_wdata_o           = wdata_q;
  assign WB_reg_write_address_o = wb_addr_q;
  assign WB_reg_write_data_o    = wb_data_q;
  assign WB_ctrl_reg_write_o    = wb_we_q;
  assign misalign_o             = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        EXMEM_valid_i;
  logic [31:0] EXMEM_alu_result_i;
  logic [31:0] EXMEM_b_i;
  logic [4:0]  EXMEM_dst_i;
  logic [1:0]  EXMEM_ctrl_mem_read_i;
  logic [1:0]  EXMEM_ctrl_mem_write_i;
  logic        EXMEM_ctrl_reg_write_i;
  logic        EXMEM_ctrl_mem_to_reg_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic        stall_o;
  logic [4:0]  WB_reg_write_address_o;
  logic [31:0] WB_reg_write_data_o;
  logic        WB_ctrl_reg_write_o;
  logic        misalign_o, bus_err_o;

  mem_wb_stage #(.DMEM_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i),
    .EXMEM_valid_i(EXMEM_valid_i), .EXMEM_alu_result_i(EXMEM_alu_result_i),
    .EXMEM_b_i(EXMEM_b_i), .EXMEM_dst_i(EXMEM_dst_i),
    .EXMEM_ctrl_mem_read_i(EXMEM_ctrl_mem_read_i),
    .EXMEM_ctrl_mem_write_i(EXMEM_ctrl_mem_write_i),
    .EXMEM_ctrl_reg_write_i(EXMEM_ctrl_reg_write_i),
    .EXMEM_ctrl_mem_to_reg_i(EXMEM_ctrl_mem_to_reg_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .stall_o(stall_o),
    .WB_reg_write_address_o(WB_reg_write_address_o),
    .WB_reg_write_data_o(WB_reg_write_data_o),
    .WB_ctrl_reg_write_o(WB_ctrl_reg_write_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [4:0] addr; logic [31:0] data; } wb_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   exp_misalign = 0;
  bit   exp_bus_err = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Reference model: sizes in bytes, big-endian byte k occupies bits [31-8k -: 8].
  function automatic void model(input logic [1:0] rd, input logic [1:0] wr,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] rdata,
                                output bit is_mem, output bit mis,
                                output bus_t bx, output logic [31:0] ld);
    int unsigned sz, nb, off;
    longint unsigned mask, v, w;
    sz   = (wr != 0) ? int'(wr) : int'(rd);
    nb   = (sz == 1) ? 4 : (sz == 2) ? 2 : 1;
    off  = a % 4;
    mask = (64'd1 << (8 * nb)) - 1;
    is_mem = (sz != 0);
    mis    = is_mem && ((off % nb) != 0);
    bx.we   = (wr != 0);
    bx.addr = a - off;
    bx.be   = '0;
    w = 0;
    for (int unsigned i = 0; i < 4 / nb; i++) w = (w << (8 * nb)) | (longint'(b) & mask);
    bx.wdata = w[31:0];
    ld = '0;
    if (!mis) begin
      for (int unsigned k = off; k < off + nb; k++) bx.be[3 - k] = 1'b1;
      v = (longint'(rdata) >> (8 * (4 - off - nb))) & mask;
      if (v[8 * nb - 1]) v = v | ~mask;
      ld = v[31:0];
    end
  endfunction

  // Runs one EX/MEM instruction to retirement, playing the memory side.
  task automatic issue(input bit v, input logic [1:0] rd, input logic [1:0] wr,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst,
                       input bit rw, input bit m2r, input int unsigned waits,
                       input logic [31:0] rdata, input bit no_ack);
    bit is_mem, mis, fin;
    bus_t bx;
    logic [31:0] ld;
    wb_t e;
    int unsigned exp_stall, n_wait, stall_cnt, cyc;
    model(rd, wr, a, b, rdata, is_mem, mis, bx, ld);
    is_mem = is_mem && v;
    mis    = mis && v;
    if (is_mem && !mis) bus_q.push_back(bx);
    if (v && rw && dst != 0 && !mis && !(is_mem && no_ack)) begin
      e.addr = dst;
      e.data = m2r ? ld : a;
      wb_q.push_back(e);
    end
    if (mis) exp_misalign = 1;
    if (is_mem && !mis && no_ack) exp_bus_err = 1;
    exp_stall = (is_mem && !mis) ? (no_ack ? TO : waits + 1) : 0;

    EXMEM_valid_i = v; EXMEM_ctrl_mem_read_i = rd; EXMEM_ctrl_mem_write_i = wr;
    EXMEM_alu_result_i = a; EXMEM_b_i = b; EXMEM_dst_i = dst;
    EXMEM_ctrl_reg_write_i = rw; EXMEM_ctrl_mem_to_reg_i = m2r;
    n_wait = 0; stall_cnt = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 64) begin
      if (dmem_req_o && !no_ack) begin
        if (n_wait == waits) begin
          dmem_ack_i = 1'b1;
          dmem_rdata_i = rdata;
        end else n_wait++;
      end
      #1;
      if (stall_o) stall_cnt++; else fin = 1;
      @(posedge clk_i); #1;
      dmem_ack_i = 1'b0;
      dmem_rdata_i = $urandom;
      @(negedge clk_i);
      cyc++;
    end
    if (!fin) begin
      errors++; checks++;
      $display("FAIL retire_timeout stall still high after %0d cycles", cyc);
    end
    check32("stall_cycles", stall_cnt, exp_stall);
    check32("req_after_retire", {31'd0, dmem_req_o}, 32'd0);
    check32("misalign_o", {31'd0, misalign_o}, {31'd0, exp_misalign});
    check32("bus_err_o", {31'd0, bus_err_o}, {31'd0, exp_bus_err});
  endtask

  // Write-back monitor: every register write must match the next expectation.
  always @(negedge clk_i) begin
    if (n_rst_i && WB_ctrl_reg_write_o) begin
      wb_t e;
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected got addr %0d data %h exp none",
                 WB_reg_write_address_o, WB_reg_write_data_o);
      end else begin
        e = wb_q.pop_front();
        check32("wb_addr", {27'd0, WB_reg_write_address_o}, {27'd0, e.addr});
        check32("wb_data", WB_reg_write_data_o, e.data);
      end
    end
  end

  // Bus monitor: request fields must match and stay stable while req is high.
  bit prev_req = 0;
  always @(negedge clk_i) begin
    if (dmem_req_o) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected got addr %h exp none", dmem_addr_o);
      end else begin
        check32("bus_we", {31'd0, dmem_we_o}, {31'd0, bus_q[0].we});
        check32("bus_addr", dmem_addr_o, bus_q[0].addr);
        check32("bus_be", {28'd0, dmem_be_o}, {28'd0, bus_q[0].be});
        if (bus_q[0].we) check32("bus_wdata", dmem_wdata_o, bus_q[0].wdata);
      end
    end else if (prev_req && bus_q.size() > 0) begin
      void'(bus_q.pop_front());
    end
    prev_req = dmem_req_o;
  end

  task automatic check_all_zero(input string tag);
    check32({tag, "_req"}, {31'd0, dmem_req_o}, 32'd0);
    check32({tag, "_we"}, {31'd0, dmem_we_o}, 32'd0);
    check32({tag, "_addr"}, dmem_addr_o, 32'd0);
    check32({tag, "_be"}, {28'd0, dmem_be_o}, 32'd0);
    check32({tag, "_wdata"}, dmem_wdata_o, 32'd0);
    check32({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    check32({tag, "_wb_we"}, {31'd0, WB_ctrl_reg_write_o}, 32'd0);
    check32({tag, "_wb_addr"}, {27'd0, WB_reg_write_address_o}, 32'd0);
    check32({tag, "_wb_data"}, WB_reg_write_data_o, 32'd0);
    check32({tag, "_misalign"}, {31'd0, misalign_o}, 32'd0);
    check32({tag, "_bus_err"}, {31'd0, bus_err_o}, 32'd0);
  endtask

  initial begin
    bus_t bx;
    bit im, mi;
    logic [31:0] ld;
    n_rst_i = 1'b0;
    EXMEM_valid_i = 0; EXMEM_alu_result_i = '0; EXMEM_b_i = '0; EXMEM_dst_i = '0;
    EXMEM_ctrl_mem_read_i = '0; EXMEM_ctrl_mem_write_i = '0;
    EXMEM_ctrl_reg_write_i = 0; EXMEM_ctrl_mem_to_reg_i = 0;
    dmem_rdata_i = '0; dmem_ack_i = 0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    n_rst_i = 1'b1;
    @(negedge clk_i);

    // directed
    issue(1, 2'd0, 2'd0, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 32'h0, 0);               // ALU
    issue(1, 2'd3, 2'd0, 32'h101, 32'h0, 5'd6, 1, 1, 3, 32'h11F2_3344, 0);        // LB
    issue(1, 2'd0, 2'd2, 32'h202, 32'hABCD_5678, 5'd0, 0, 0, 0, 32'h0, 0);        // SH
    issue(1, 2'd1, 2'd0, 32'h303, 32'h0, 5'd8, 1, 1, 0, 32'h0, 0);                // LW misaligned
    issue(1, 2'd1, 2'd0, 32'h400, 32'h0, 5'd0, 1, 1, 1, 32'hDEAD_BEEF, 0);        // LW to r0
    issue(1, 2'd1, 2'd2, 32'h502, 32'h1111_2222, 5'd3, 0, 0, 0, 32'h0, 0);        // both: store wins
    issue(1, 2'd2, 2'd0, 32'h600, 32'h0, 5'd4, 1, 1, 2, 32'h8001_7FFF, 0);        // LH offset 0
    issue(1, 2'd2, 2'd0, 32'h602, 32'h0, 5'd4, 1, 1, 0, 32'h8001_7FFF, 0);        // LH offset 2
    issue(0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 0);                  // bubble

    // randomized
    for (int i = 0; i < 200; i++) begin
      int unsigned kind, sz, nb;
      logic [31:0] a;
      logic [1:0] rd, wr;
      bit rw, m2r;
      kind = $urandom_range(0, 5);
      sz = $urandom_range(1, 3);
      nb = (sz == 1) ? 4 : (sz == 2) ? 2 : 1;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(nb - 1);
      rd = 0; wr = 0; rw = 0; m2r = 0;
      if (kind == 1) rw = 1'($urandom_range(0, 1));
      else if (kind <= 3 && kind >= 2) begin rd = 2'(sz); rw = 1; m2r = 1; end
      else if (kind >= 4) begin wr = 2'(sz); rd = 2'($urandom_range(0, 3)); end
      issue(kind != 0, rd, wr, a, $urandom, 5'($urandom_range(0, 31)), rw, m2r,
            $urandom_range(0, 3), $urandom, 0);
    end

`ifdef DMEM_TIMEOUT_EN
    issue(1, 2'd1, 2'd0, 32'h700, 32'h0, 5'd9, 1, 1, 0, 32'h0, 1);
    issue(1, 2'd0, 2'd0, 32'h55, 32'h0, 5'd10, 1, 0, 0, 32'h0, 0);
    issue(1, 2'd1, 2'd0, 32'h704, 32'h0, 5'd11, 1, 1, TO - 1, 32'h0BAD_F00D, 0);
`endif

    // asynchronous reset during BUSY
    model(2'd1, 2'd0, 32'h800, 32'h0, 32'h0, im, mi, bx, ld);
    bus_q.push_back(bx);
    EXMEM_valid_i = 1; EXMEM_ctrl_mem_read_i = 2'd1; EXMEM_ctrl_mem_write_i = 2'd0;
    EXMEM_alu_result_i = 32'h800; EXMEM_dst_i = 5'd7;
    EXMEM_ctrl_reg_write_i = 1; EXMEM_ctrl_mem_to_reg_i = 1;
    @(posedge clk_i); @(negedge clk_i);
    check32("busy_req", {31'd0, dmem_req_o}, 32'd1);
    #2 n_rst_i = 1'b0;
    #1 check_all_zero("midreset");
    EXMEM_valid_i = 0;
    exp_misalign = 0; exp_bus_err = 0;
    @(negedge clk_i);
    n_rst_i = 1'b1;
    issue(1, 2'd0, 2'd0, 32'hCAFE, 32'h0, 5'd12, 1, 0, 0, 32'h0, 0);
    issue(0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 0);
    @(negedge clk_i);

    check32("wb_queue_left", wb_q.size(), 32'd0);
    check32("bus_queue_left", bus_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
